// File: rtl/inst_fetch_responder_pkg.sv
// Shared definitions for the instruction fetch responder: refill FSM encoding
// and the PC field positions used to address a direct-mapped cache of 2-word lines.
package inst_fetch_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2
  } fetch_state_t;

  localparam int LINE_BYTES = 8;
  localparam int WORD_BYTES = 4;
  localparam int OFF_BIT    = 2;   // selects word within the line
  localparam int IDX_LSB    = 3;   // first index bit, just above the line offset

  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_lsb(input int lines);
    return IDX_LSB + $clog2(lines);
  endfunction

endpackage

// File: rtl/inst_fetch_responder_line_store.sv
// Tag/data/valid storage for the instruction cache: combinational lookup,
// per-word synchronous refill writes, and a single-cycle clear of every valid bit.
module icache_line_store
  import inst_fetch_responder_pkg::*;
#(
  parameter int LINES  = 64,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 23,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_all,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_word0,
  output logic [DATA_W-1:0] rd_word1,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_word0_en,
  input  logic              wr_word1_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [TAG_W-1:0]  wr_tag
);

  logic [LINES-1:0]  valid_reg;
  logic [TAG_W-1:0]  tag_mem   [LINES];
  logic [DATA_W-1:0] word0_mem [LINES];
  logic [DATA_W-1:0] word1_mem [LINES];

  // Valid is set only with the second word, so a half-filled line never hits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (clr_all) begin
      valid_reg <= '0;
    end else if (wr_word1_en) begin
      valid_reg[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_word0_en) begin
      word0_mem[wr_idx] <= wr_data;
    end
    if (wr_word1_en) begin
      word1_mem[wr_idx] <= wr_data;
      tag_mem[wr_idx]   <= wr_tag;
    end
  end

  assign rd_valid = valid_reg[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_word0 = word0_mem[rd_idx];
  assign rd_word1 = word1_mem[rd_idx];

endmodule

// File: rtl/inst_fetch_responder.sv
// Direct-mapped instruction cache answering IF-stage fetches; misses stall IF
// while the 2-word line is refilled over a ready/enable read port.
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
#(
  parameter int LINES  = 64,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [31:0]       fetch_pc,
  input  logic              inv_all,
  output logic [DATA_W-1:0] instruction,
  output logic              pause,
  output logic              mem_rd_en,
  output logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int IDX_W   = idx_width(LINES);
  localparam int TAG_LSB = tag_lsb(LINES);
  localparam int TAG_W   = 32 - TAG_LSB;

  fetch_state_t      state_reg, state_next;
  logic [31:0]       miss_addr_reg, miss_addr_next;
  logic              wr_word0_en, wr_word1_en;
  logic              rd_valid, hit;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_word0, rd_word1;
  logic              pc_byte_unused;

  assign pc_byte_unused = ^fetch_pc[OFF_BIT-1:0];

  icache_line_store #(
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_line_store (
    .clk         (clk),
    .rst         (rst),
    .clr_all     (inv_all),
    .rd_idx      (fetch_pc[TAG_LSB-1:IDX_LSB]),
    .rd_valid    (rd_valid),
    .rd_tag      (rd_tag),
    .rd_word0    (rd_word0),
    .rd_word1    (rd_word1),
    .wr_idx      (miss_addr_reg[TAG_LSB-1:IDX_LSB]),
    .wr_word0_en (wr_word0_en),
    .wr_word1_en (wr_word1_en),
    .wr_data     (mem_rdata),
    .wr_tag      (miss_addr_reg[31:TAG_LSB])
  );

  assign hit         = (state_reg == IDLE) && rd_valid && (rd_tag == fetch_pc[31:TAG_LSB]);
  assign instruction = hit ? (fetch_pc[OFF_BIT] ? rd_word1 : rd_word0) : '0;
  assign pause       = fetch_valid && !hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      miss_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      miss_addr_reg <= miss_addr_next;
    end
  end

  // Memory port outputs decode straight from state so reset drops them without a clock.
  always_comb begin
    state_next     = state_reg;
    miss_addr_next = miss_addr_reg;
    mem_rd_en      = 1'b0;
    mem_addr       = '0;
    wr_word0_en    = 1'b0;
    wr_word1_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fetch_valid && !hit) begin
          miss_addr_next = {fetch_pc[31:IDX_LSB], {IDX_LSB{1'b0}}};
          state_next     = RD0;
        end
      end
      RD0: begin
        mem_rd_en = 1'b1;
        mem_addr  = miss_addr_reg;
        if (inv_all) begin
          state_next = IDLE;
        end else if (mem_ready) begin
          wr_word0_en = 1'b1;
          state_next  = RD1;
        end
      end
      RD1: begin
        mem_rd_en = 1'b1;
        mem_addr  = miss_addr_reg + 32'(WORD_BYTES);
        if (inv_all) begin
          state_next = IDLE;
        end else if (mem_ready) begin
          wr_word1_en = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder: a table of fetches against a
// latency-configurable memory model, plus hand sequences for abort/reset/zero-wait.
module tb_inst_fetch_responder;

  logic        clk = 1'b0;
  logic        rst, fetch_valid, inv_all, pause, mem_rd_en, mem_ready;
  logic [31:0] fetch_pc, instruction, mem_addr, mem_rdata;

  int tests  = 0;
  int failed = 0;
  int lat    = 2;
  int beat_cnt = 0;
  int rd_cycles = 0;
  logic [31:0] beats[$];

  typedef struct {
    logic [31:0] pc;
    int          lat;
    int          stalls;
  } vec_t;
  vec_t vecs[12];

  always #5 clk = ~clk;

  inst_fetch_responder dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .inv_all     (inv_all),
    .instruction (instruction),
    .pause       (pause),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {a[15:0], a[15:0]} ^ 32'h0000_1357;
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  // lat==0: ready tied high; otherwise ready in the 2nd cycle of each beat.
  always @(negedge clk) begin
    if (!mem_rd_en) begin
      beat_cnt  = 0;
      mem_ready = (lat == 0);
    end else if (lat == 0) begin
      mem_ready = 1'b1;
    end else begin
      mem_ready = (beat_cnt == 1);
      beat_cnt  = mem_ready ? 0 : beat_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (mem_rd_en) rd_cycles++;
    if (mem_rd_en && mem_ready) beats.push_back(mem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered just after a negedge; returns just after a later negedge.
  task automatic fetch(input logic [31:0] pc, input int exp_stalls, input string name);
    int stalls;
    logic [31:0] base;
    stalls = 0;
    base = {pc[31:3], 3'b000};
    beats.delete();
    rd_cycles = 0;
    fetch_pc = pc;
    fetch_valid = 1'b1;
    #1;
    if (exp_stalls > 0) check({name, " miss instr"}, instruction, 32'd0);
    while (pause && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check({name, " stalls"}, 32'(stalls), 32'(exp_stalls));
    check({name, " instr"}, instruction, mem_word({pc[31:2], 2'b00}));
    @(negedge clk);
    #1;
    if (exp_stalls > 0) begin
      check({name, " beats"}, 32'(beats.size()), 32'd2);
      if (beats.size() >= 2) begin
        check({name, " addr0"}, beats[0], base);
        check({name, " addr1"}, beats[1], base + 32'd4);
      end
    end else begin
      check({name, " rd_cycles"}, 32'(rd_cycles), 32'd0);
    end
    $display("[TB] fetch %s pc=%h stalls=%0d instr=%h", name, pc, stalls, mem_word({pc[31:2], 2'b00}));
  endtask

  initial begin
    int n;
    vecs[0]  = '{32'd0,   2, 5};
    vecs[1]  = '{32'd4,   2, 0};
    vecs[2]  = '{32'd512, 2, 5};
    vecs[3]  = '{32'd516, 2, 0};
    vecs[4]  = '{32'd0,   2, 5};
    vecs[5]  = '{32'd8,   0, 3};
    vecs[6]  = '{32'd16,  0, 3};
    vecs[7]  = '{32'd24,  0, 3};
    vecs[8]  = '{32'd12,  2, 0};
    vecs[9]  = '{32'd20,  2, 0};
    vecs[10] = '{32'd4,   2, 0};
    vecs[11] = '{32'd28,  2, 0};

    rst = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; inv_all = 1'b0; mem_ready = 1'b0;
    #12;
    check("rst pause", {31'd0, pause}, 32'd0);
    check("rst rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst addr", mem_addr, 32'd0);
    check("rst instr", instruction, 32'd0);
    fetch_valid = 1'b1;
    #1;
    check("rst pause follows fv", {31'd0, pause}, 32'd1);
    fetch_valid = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;

    // Tests 1 and 2: cold miss, hit on neighbour word, conflict eviction, refill.
    for (int i = 0; i < 12; i++) begin
      lat = vecs[i].lat;
      fetch(vecs[i].pc, vecs[i].stalls, $sformatf("vec%0d", i));
    end

    // Test 3: invalidate, then abort a refill during RD1.
    fetch_valid = 1'b0;
    inv_all = 1'b1;
    @(posedge clk); #1;
    inv_all = 1'b0;
    @(negedge clk); #1;
    lat = 2;
    beats.delete();
    fetch_pc = 32'd8;
    fetch_valid = 1'b1;
    #1;
    check("t3 miss after inv", {31'd0, pause}, 32'd1);
    n = 0;
    while (!(mem_rd_en && mem_addr == 32'd12) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("t3 reach RD1", mem_addr, 32'd12);
    inv_all = 1'b1;
    @(posedge clk); #1;
    inv_all = 1'b0;
    @(negedge clk); #1;
    check("t3 abort rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("t3 abort pause", {31'd0, pause}, 32'd1);
    check("t3 abort beats", 32'(beats.size()), 32'd1);
    $display("[TB] inv_all during RD1 pc=00000008");
    fetch(32'd8, 5, "t3 remiss");
    fetch(32'd16, 5, "t3 cleared");

    // Test 4: no request, no refill.
    fetch_valid = 1'b0;
    fetch_pc = 32'd40;
    rd_cycles = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t4 pause", {31'd0, pause}, 32'd0);
      check("t4 rd_en", {31'd0, mem_rd_en}, 32'd0);
      @(negedge clk); #1;
    end
    check("t4 rd_cycles", 32'(rd_cycles), 32'd0);
    $display("[TB] idle pc=00000028 fetch_valid=0");

    // Test 5: async reset mid-RD0.
    fetch(32'd0, 5, "t5 fill");
    fetch_pc = 32'd32;
    fetch_valid = 1'b1;
    #1;
    @(negedge clk); #1;
    check("t5 rd0 rd_en", {31'd0, mem_rd_en}, 32'd1);
    check("t5 rd0 addr", mem_addr, 32'd32);
    rst = 1'b1;
    #1;
    check("t5 rst rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("t5 rst addr", mem_addr, 32'd0);
    check("t5 rst pause", {31'd0, pause}, 32'd1);
    check("t5 rst instr", instruction, 32'd0);
    fetch_valid = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    $display("[TB] reset during RD0 pc=00000020");
    fetch(32'd0, 5, "t5 remiss");

    // Test 6: zero-wait memory.
    lat = 0;
    fetch(32'd16, 3, "t6 zero-wait");
    fetch(32'd20, 0, "t6 hit");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
